jesd204b_data_link: RTL and testbench

//  JESD204B TX data-link layer with internal RX loopback. Sits between the transport layer and the 8b/10b/PHY.

---
 rtl/jesd204b_pkg.sv | 20 ++
 rtl/jesd204b_lane_scrambler.sv | 44 ++++
 rtl/jesd204b_data_link.sv | 230 +++++++++++++++++++++++
 tb/tb_jesd204b_data_link.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_pkg.sv
// Shared constants and types for the JESD204B TX data-link layer.
// Covers the control characters, link states and phase lengths in multiframes.
package jesd204b_pkg;

  localparam logic [7:0] K_K = 8'hBC;  // /K/ K28.5, code-group sync
  localparam logic [7:0] K_R = 8'h1C;  // /R/ ILAS multiframe start
  localparam logic [7:0] K_Q = 8'h9C;  // /Q/ precedes the config octets
  localparam logic [7:0] K_A = 8'h7C;  // /A/ multiframe alignment
  localparam logic [7:0] K_F = 8'hFC;  // /F/ frame alignment

  localparam int CGS_MF  = 2;
  localparam int ILAS_MF = 4;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } link_state_e;

endpackage

// File: rtl/jesd204b_lane_scrambler.sv
// Scrambler or descrambler for one lane, using 1 + x^14 + x^15 and OPS octets per clock.
// Octets are taken in index order and bits MSB first. The state advances only while enable is high.
module jesd204b_lane_scrambler #(
  parameter int OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             descramble,
  input  logic [8*OPS-1:0] din,
  output logic [8*OPS-1:0] dout
);

  logic [14:0] lfsr_q;
  logic [14:0] lfsr_d;
  logic        b_in;
  logic        b_out;

  // The register always shifts in the scrambled bit.
  // On TX that bit is the output; on RX it is the input.
  always_comb begin
    lfsr_d = lfsr_q;
    dout   = '0;
    b_in   = 1'b0;
    b_out  = 1'b0;
    for (int i = 0; i < OPS; i++) begin
      for (int j = 7; j >= 0; j--) begin
        b_in  = din[8*(OPS-1-i)+j];
        b_out = b_in ^ lfsr_d[14] ^ lfsr_d[13];
        dout[8*(OPS-1-i)+j] = b_out;
        lfsr_d = {lfsr_d[13:0], (descramble ? b_in : b_out)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 15'h7FFF;
    end else if (enable) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/jesd204b_data_link.sv
// JESD204B TX data link: CGS, then ILAS, then user data with optional scrambling and /F/ /A/ replacement.
// An internal RX loopback undoes both steps and drives `out` with aligned frame and multiframe markers.
module jesd204b_data_link
  import jesd204b_pkg::*;
#(
  parameter int LANE_DATA_WIDTH = 32,
  parameter int OCTET_PER_SENT  = 4,
  parameter int LANES           = 1,
  parameter int OCTETS_PER_FR   = 5,
  parameter int FRAMES_PER_MF   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               scramble_enable,
  input  logic [111:0]                       in_config,
  input  logic [LANE_DATA_WIDTH*LANES-1:0]   in,
  output logic [LANE_DATA_WIDTH*LANES-1:0]   out_tx,
  output logic [LANE_DATA_WIDTH*LANES-1:0]   out,
  output logic [OCTET_PER_SENT-1:0]          sof,
  output logic [OCTET_PER_SENT-1:0]          eof,
  output logic [OCTET_PER_SENT-1:0]          som,
  output logic [OCTET_PER_SENT-1:0]          eom,
  output logic                               LMFC
);

  localparam int LDW    = LANE_DATA_WIDTH;
  localparam int OPS    = OCTET_PER_SENT;
  localparam int F      = OCTETS_PER_FR;
  localparam int OCT_MF = F * FRAMES_PER_MF;
  localparam int BEATS  = OCT_MF / OPS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  link_state_e          state_q, tx_state_q;
  logic [BW-1:0]        beat_q, tx_beat_q;
  logic [2:0]           mf_q;
  logic                 tx_scr_q;
  logic [LDW-1:0]       ctrl_word;
  logic [LDW*LANES-1:0] tx_next, rx_next;
  logic [OPS-1:0]       sof_d, eof_d, som_d, eom_d;
  int                   cn, mn;

  // Phase changes only on the last beat, so every phase starts on a multiframe boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CGS;
      beat_q  <= '0;
      mf_q    <= '0;
    end else if (beat_q == BW'(BEATS-1)) begin
      beat_q <= '0;
      case (state_q)
        CGS: begin
          if (mf_q == 3'(CGS_MF-1)) begin
            state_q <= ILAS;
            mf_q    <= '0;
          end else begin
            mf_q <= mf_q + 3'd1;
          end
        end
        ILAS: begin
          if (mf_q == 3'(ILAS_MF-1)) begin
            state_q <= DATA;
            mf_q    <= '0;
          end else begin
            mf_q <= mf_q + 3'd1;
          end
        end
        default: mf_q <= '0;
      endcase
    end else begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // CGS and ILAS words are the same on every lane.
  // The second ILAS multiframe carries /Q/ and the link configuration.
  always_comb begin
    ctrl_word = '0;
    cn        = 0;
    for (int i = 0; i < OPS; i++) begin
      cn = int'(beat_q) * OPS + i;
      if (state_q == CGS) begin
        ctrl_word[LDW-1-8*i -: 8] = K_K;
      end else if (cn == 0) begin
        ctrl_word[LDW-1-8*i -: 8] = K_R;
      end else if (cn == OCT_MF-1) begin
        ctrl_word[LDW-1-8*i -: 8] = K_A;
      end else if (mf_q == 3'd1 && cn == 1) begin
        ctrl_word[LDW-1-8*i -: 8] = K_Q;
      end else if (mf_q == 3'd1 && cn >= 2 && cn <= 15) begin
        ctrl_word[LDW-1-8*i -: 8] = in_config[111-8*(cn-2) -: 8];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LDW-1:0] tx_raw, tx_scr, tx_d;
    logic [LDW-1:0] rx_raw, rx_dscr, rx_d;
    logic [7:0]     tx_prev_q, tx_prev_d, rx_prev_q, rx_prev_d, tx_oct, rx_oct;
    logic           tx_pv_q, tx_pv_d, rx_pv_q, rx_pv_d;
    int             tn, rn;

    assign tx_raw = in[l*LDW +: LDW];
    assign rx_raw = out_tx[l*LDW +: LDW];

    jesd204b_lane_scrambler #(.OPS(OPS)) u_tx_scr (
      .clk        (clk),
      .rst        (reset),
      .enable     (state_q == DATA && scramble_enable),
      .descramble (1'b0),
      .din        (tx_raw),
      .dout       (tx_scr)
    );

    jesd204b_lane_scrambler #(.OPS(OPS)) u_rx_scr (
      .clk        (clk),
      .rst        (reset),
      .enable     (tx_state_q == DATA && tx_scr_q),
      .descramble (1'b1),
      .din        (rx_raw),
      .dout       (rx_dscr)
    );

    // The last octet of each frame is remembered unreplaced.
    // It is also remembered while scrambling, so replacement is correct when scrambling turns off.
    always_comb begin
      tx_d      = (state_q == DATA) ? (scramble_enable ? tx_scr : tx_raw) : ctrl_word;
      tx_prev_d = tx_prev_q;
      tx_pv_d   = (state_q == DATA) ? tx_pv_q : 1'b0;
      tx_oct    = '0;
      tn        = 0;
      if (state_q == DATA) begin
        for (int i = 0; i < OPS; i++) begin
          tn = int'(beat_q) * OPS + i;
          if (tn % F == F-1) begin
            tx_oct = tx_raw[LDW-1-8*i -: 8];
            if (!scramble_enable && tx_pv_d && tx_oct == tx_prev_d)
              tx_d[LDW-1-8*i -: 8] = (tn == OCT_MF-1) ? K_A : K_F;
            tx_prev_d = tx_oct;
            tx_pv_d   = 1'b1;
          end
        end
      end
    end

    always_comb begin
      rx_d      = '0;
      rx_prev_d = rx_prev_q;
      rx_pv_d   = (tx_state_q == DATA) ? rx_pv_q : 1'b0;
      rx_oct    = '0;
      rn        = 0;
      if (tx_state_q == DATA) begin
        rx_d = tx_scr_q ? rx_dscr : rx_raw;
        for (int i = 0; i < OPS; i++) begin
          rn = int'(tx_beat_q) * OPS + i;
          if (rn % F == F-1) begin
            rx_oct = rx_d[LDW-1-8*i -: 8];
            if (!tx_scr_q && rx_pv_d && (rx_oct == K_F || rx_oct == K_A)) begin
              rx_oct = rx_prev_d;
              rx_d[LDW-1-8*i -: 8] = rx_oct;
            end
            rx_prev_d = rx_oct;
            rx_pv_d   = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tx_prev_q <= '0;
        tx_pv_q   <= 1'b0;
        rx_prev_q <= '0;
        rx_pv_q   <= 1'b0;
      end else begin
        tx_prev_q <= tx_prev_d;
        tx_pv_q   <= tx_pv_d;
        rx_prev_q <= rx_prev_d;
        rx_pv_q   <= rx_pv_d;
      end
    end

    assign tx_next[l*LDW +: LDW] = tx_d;
    assign rx_next[l*LDW +: LDW] = rx_d;
  end

  // Markers follow the beat that is now on out_tx, so they line up with `out` one clock later.
  always_comb begin
    sof_d = '0;
    eof_d = '0;
    som_d = '0;
    eom_d = '0;
    mn    = 0;
    for (int i = 0; i < OPS; i++) begin
      mn = int'(tx_beat_q) * OPS + i;
      if (tx_state_q != CGS) begin
        sof_d[i] = (mn % F == 0);
        eof_d[i] = (mn % F == F-1);
        som_d[i] = (mn == 0);
        eom_d[i] = (mn == OCT_MF-1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_tx     <= '0;
      LMFC       <= 1'b0;
      tx_state_q <= CGS;
      tx_beat_q  <= '0;
      tx_scr_q   <= 1'b0;
      out        <= '0;
      sof        <= '0;
      eof        <= '0;
      som        <= '0;
      eom        <= '0;
    end else begin
      out_tx     <= tx_next;
      LMFC       <= (beat_q == '0);
      tx_state_q <= state_q;
      tx_beat_q  <= beat_q;
      tx_scr_q   <= scramble_enable;
      out        <= rx_next;
      sof        <= sof_d;
      eof        <= eof_d;
      som        <= som_d;
      eom        <= eom_d;
    end
  end

endmodule

// File: tb/tb_jesd204b_data_link.sv
// Randomised bench for jesd204b_data_link. It uses an octet-stream reference model
// built from absolute octet position, multiframe number and a bit-serial LFSR.
module tb_jesd204b_data_link;

  logic          clk = 1'b0;
  logic          rst;
  logic          scramble_enable;
  logic [111:0]  cfg;
  logic [31:0]   in_data;
  logic [31:0]   out_tx, out;
  logic [3:0]    sof, eof, som, eom;
  logic          LMFC;

  jesd204b_data_link dut (
    .clk             (clk),
    .reset           (rst),
    .scramble_enable (scramble_enable),
    .in_config       (cfg),
    .in              (in_data),
    .out_tx          (out_tx),
    .out             (out),
    .sof             (sof),
    .eof             (eof),
    .som             (som),
    .eom             (eom),
    .LMFC            (LMFC)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          k;
  logic [14:0] m_lfsr;
  logic [7:0]  m_prev;
  bit          m_pv;
  bit          seen_nz;
  logic [31:0] exp_q[$];
  logic [15:0] mk_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
  endtask

  task automatic model_reset();
    k       = 0;
    m_lfsr  = 15'h7FFF;
    m_prev  = 8'h00;
    m_pv    = 1'b0;
    exp_q.delete();
    mk_q.delete();
    exp_q.push_back(32'h0);
    mk_q.push_back(16'h0);
  endtask

  function automatic logic [7:0] scr_octet(input logic [7:0] d);
    logic [7:0] s;
    s = '0;
    for (int b = 7; b >= 0; b--) begin
      s[b]   = d[b] ^ m_lfsr[14] ^ m_lfsr[13];
      m_lfsr = {m_lfsr[13:0], s[b]};
    end
    return s;
  endfunction

  // Link timeline in octets: 20 octets per multiframe.
  // Multiframes 0-1 are CGS, 2-5 are ILAS (config in the second ILAS multiframe), 6 onward is data.
  task automatic model_step(input logic [31:0] in_v, input bit scr_v,
                            output logic [31:0] tx_e, output logic [31:0] rx_e,
                            output logic [15:0] mk_e);
    int nabs, m, n;
    logic [7:0] d, s;
    logic [3:0] so, eo, sm, em;
    tx_e = '0; rx_e = '0; so = '0; eo = '0; sm = '0; em = '0;
    for (int i = 0; i < 4; i++) begin
      nabs = k * 4 + i;
      m    = nabs / 20;
      n    = nabs % 20;
      d    = in_v[31-8*i -: 8];
      if (m < 2) begin
        s = 8'hBC;
      end else if (m < 6) begin
        s = 8'h00;
        if (n == 0) s = 8'h1C;
        else if (n == 19) s = 8'h7C;
        else if (m == 3 && n == 1) s = 8'h9C;
        else if (m == 3 && n >= 2 && n <= 15) s = cfg[111-8*(n-2) -: 8];
      end else begin
        if (scr_v) begin
          s = scr_octet(d);
        end else begin
          s = d;
          if (n % 5 == 4 && m_pv && d == m_prev) s = (n == 19) ? 8'h7C : 8'hFC;
        end
        if (n % 5 == 4) begin
          m_prev = d;
          m_pv   = 1'b1;
        end
        rx_e[31-8*i -: 8] = d;
      end
      tx_e[31-8*i -: 8] = s;
      if (m >= 2) begin
        so[i] = (n % 5 == 0);
        eo[i] = (n % 5 == 4);
        sm[i] = (n == 0);
        em[i] = (n == 19);
      end
    end
    mk_e = {so, eo, sm, em};
  endtask

  // driver: one clock with given inputs, then scoreboard compare
  task automatic run_cycle(input logic [31:0] in_v, input bit scr_v);
    logic [31:0] tx_e, rx_e;
    logic [15:0] mk_e;
    in_data         = in_v;
    scramble_enable = scr_v;
    model_step(in_v, scr_v, tx_e, rx_e, mk_e);
    @(posedge clk);
    #1;
    check("out_tx", out_tx, tx_e);
    check("lmfc", 32'(LMFC), 32'((k % 5) == 0));
    check("out", out, exp_q.pop_front());
    check("markers", 32'({sof, eof, som, eom}), 32'(mk_q.pop_front()));
    if (k == 15) check("ilas_mf2_beat0", out_tx, 32'h1C9C7777);
    if (out_tx != 32'h0) seen_nz = 1'b1;
    exp_q.push_back(rx_e);
    mk_q.push_back(mk_e);
    k++;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [7:0]  oct;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       oct = 8'h11;
        1:       oct = 8'h22;
        2:       oct = 8'h5A;
        default: oct = 8'($urandom_range(0, 8'h7B));
      endcase
      w[31-8*i -: 8] = oct;
    end
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_out_tx"}, out_tx, 32'h0);
    check({tag, "_out"}, out, 32'h0);
    check({tag, "_markers"}, 32'({sof, eof, som, eom}), 32'h0);
    check({tag, "_lmfc"}, 32'(LMFC), 32'h0);
  endtask

  initial begin
    bit scr;
    logic [31:0] v;
    rst             = 1'b1;
    in_data         = '0;
    scramble_enable = 1'b0;
    cfg             = 112'h7777777788888888777777778888;
    k               = 0;
    repeat (60) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // CGS then ILAS
    repeat (30) run_cycle(32'h0, 1'b0);
    // constant data: replacement from the second frame on
    repeat (25) run_cycle(32'h11111111, 1'b0);
    // stepping data every 25 clocks
    for (int s = 2; s <= 5; s++) begin
      v = 32'h11111111 * 32'(s);
      repeat (25) run_cycle(v, 1'b0);
    end
    // scrambled zeros
    seen_nz = 1'b0;
    repeat (30) run_cycle(32'h0, 1'b1);
    check("scrambler_fills", 32'(seen_nz), 32'h1);
    // random data, scrambling toggled at random
    scr = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) scr = ~scr;
      run_cycle(rand_word(), scr);
    end

    // asynchronous reset in the middle of DATA
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("held_reset");
    rst = 1'b0;
    model_reset();
    repeat (30) run_cycle(32'h0, 1'b0);
    for (int c = 0; c < 40; c++) run_cycle(rand_word(), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1, "timeout");
  end

endmodule
